// File: rtl/pc_hazard_ctrl_if.sv
// Fetch/hazard control bundle between the riscv_pipeline datapath and pc_hazard_ctrl.
// The slave modport is the controller side; master is the pipeline (or bench) side.
interface pc_hazard_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             imem_ready;
    logic             id_ex_MemRead;
    logic [4:0]       id_ex_rd;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             ex_branch_taken;
    logic [XLEN-1:0]  ex_branch_target;

    logic [XLEN-1:0]  pc_current;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  pc_next;
    logic             PCWrite;
    logic             PCSrc;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             fetch_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             fetch_error;

    modport master (
        output imem_ready, id_ex_MemRead, id_ex_rd, if_id_rs1, if_id_rs2,
               ex_branch_taken, ex_branch_target,
        input  pc_current, pc_plus4, pc_next, PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush,
               ID_EX_Flush, fetch_valid, stall_count, flush_count, fetch_error
    );

    modport slave (
        input  imem_ready, id_ex_MemRead, id_ex_rd, if_id_rs1, if_id_rs2,
               ex_branch_taken, ex_branch_target,
        output pc_current, pc_plus4, pc_next, PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush,
               ID_EX_Flush, fetch_valid, stall_count, flush_count, fetch_error
    );
endinterface

// File: rtl/pc_hazard_ctrl.sv
// Fetch PC owner and hazard sequencer for the 5-stage riscv_pipeline.
// Handles load-use stalls, taken-branch redirects, imem wait states with a
// timeout, and keeps saturating stall/flush counters.
module pc_hazard_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     MEM_TIMEOUT  = 16,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    pc_hazard_ctrl_if.slave bus
);

    // Wide enough to hold MEM_TIMEOUT itself
    localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WaitLast = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {StBoot, StRun, StWaitMem, StHalt} state_t;

    state_t           state, state_next;
    logic [WCW-1:0]   wait_cnt, wait_cnt_next;

    // Names kept identical to the pipeline top for hierarchical probing
    logic [XLEN-1:0]  pc_current, pc_plus4, pc_next, target;
    logic             PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, fetch_valid;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic             fetch_error;

    logic             load_use;
    logic             stall_inc, flush_inc, error_set;

    assign target   = {bus.ex_branch_target[XLEN-1:2], 2'b00};
    assign pc_plus4 = pc_current + XLEN'(4);
    assign pc_next  = PCSrc ? target : pc_plus4;

    assign load_use = bus.id_ex_MemRead && (bus.id_ex_rd != 5'd0) &&
                      ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));

    // Control decode: branch beats load-use beats imem wait beats normal fetch
    always_comb begin
        PCWrite       = 1'b0;
        PCSrc         = 1'b0;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        fetch_valid   = 1'b0;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        error_set     = 1'b0;
        if (reset) begin
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else begin
            unique case (state)
                StBoot: begin
                    IF_ID_Flush = 1'b1;
                    state_next  = StRun;
                end
                StRun, StWaitMem: begin
                    if (bus.ex_branch_taken) begin
                        PCSrc         = 1'b1;
                        PCWrite       = 1'b1;
                        IF_ID_Flush   = 1'b1;
                        ID_EX_Flush   = 1'b1;
                        flush_inc     = 1'b1;
                        state_next    = StRun;
                        wait_cnt_next = '0;
                    end else if (load_use) begin
                        // Bubble into EX clears MemRead, so this lasts one cycle
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (!bus.imem_ready) begin
                        IF_ID_Flush   = 1'b1;
                        stall_inc     = 1'b1;
                        wait_cnt_next = wait_cnt + WCW'(1);
                        if (wait_cnt == WaitLast) begin
                            state_next = StHalt;
                            error_set  = 1'b1;
                        end else begin
                            state_next = StWaitMem;
                        end
                    end else begin
                        PCWrite       = 1'b1;
                        fetch_valid   = 1'b1;
                        state_next    = StRun;
                        wait_cnt_next = '0;
                    end
                end
                StHalt: begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // PC, FSM state, wait counter, saturating perf counters and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_current  <= RESET_VECTOR;
            state       <= StBoot;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
            fetch_error <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (PCWrite) begin
                pc_current <= pc_next;
            end
            if (stall_inc && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_inc && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (error_set) begin
                fetch_error <= 1'b1;
            end
        end
    end

    assign bus.pc_current  = pc_current;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.pc_next     = pc_next;
    assign bus.PCWrite     = PCWrite;
    assign bus.PCSrc       = PCSrc;
    assign bus.IF_ID_Write = IF_ID_Write;
    assign bus.IF_ID_Flush = IF_ID_Flush;
    assign bus.ID_EX_Flush = ID_EX_Flush;
    assign bus.fetch_valid = fetch_valid;
    assign bus.stall_count = stall_count;
    assign bus.flush_count = flush_count;
    assign bus.fetch_error = fetch_error;

endmodule
